ir_nec_decoder: RTL
===================

# ir_nec_decoder

Decodes NEC-protocol frames from the DE2-115 IR receiver pin (IRDA_RXD) into a validated 8-bit command byte that feeds the drive FSM's `IR_button` input. It sits directly upstream of the FSM and replaces the raw-pin handling inside the IR path. It measures pulse durations with a cycle counter and classifies leader, bit and stop pulses against tolerance windows. It shifts in 32 bits, checks the inverted-byte redundancy, and reports valid commands, repeat codes and framing errors as single-cycle pulses.

## Interface
- `CLK_KHZ`, 50_000, clock frequency in kHz. All pulse windows are derived as µs × CLK_KHZ / 1000.
- `CHECK_ADDR`, 1, when 1, require address == ~address_inv; when 0, accept extended 16-bit addresses.

Ports:
- `clk_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; one clock domain only.
- `irda_rxd`  in  1  raw receiver output, asynchronous, idles high, low during carrier burst.
- `IR_button`  out  8  last valid command byte, held until the next valid frame.
- `ir_address`  out  8  address byte of the last valid frame.
- `button_valid`  out  1  one-cycle pulse when `IR_button` updates.
- `button_repeat`  out  1  one-cycle pulse on a valid repeat code.
- `frame_error`  out  1  one-cycle pulse when a frame is aborted after a valid leader.

## Operation
- The input passes through a 2-FF synchronizer. Both flops reset to 1. An edge detector follows.
- The duration counter is 20 bits wide. It clears on every synchronized edge and saturates at all-ones.
- Windows (µs):
  - leader low 8000–10000
  - leader high new 4000–5000
  - leader high repeat 2000–2500
  - burst low 400–700
  - space 0: 400–700
  - space 1: 1400–1900
- Bounds are inclusive. The duration is evaluated on the edge that ends the phase.
- States:
  - IDLE: a falling edge moves to LEAD_LOW.
  - LEAD_LOW: on the rising edge, an in-window duration moves to LEAD_HIGH. A short duration returns silently to IDLE (glitch, no error pulse).
  - LEAD_HIGH: on the falling edge, a new-window duration moves to BIT_LOW with bit index 0. A repeat-window duration moves to REP_STOP.
  - BIT_LOW: a burst-window duration moves to BIT_HIGH.
  - BIT_HIGH: on the falling edge, the space is classified as 0 or 1 and shifted in, LSB first. Index 31 moves to STOP; otherwise the next state is BIT_LOW.
  - STOP / REP_STOP: a burst-window low ending in a rising edge completes the frame.
- Any out-of-window duration, or counter exceeding the current phase maximum without an edge, gives `frame_error` and IDLE. The timeout fires on the cycle the count exceeds the maximum. The sole exception is a short LEAD_LOW.
- Frame check at STOP completion: byte2 == ~byte3, and (if CHECK_ADDR) byte0 == ~byte1.
  - Pass: latch `IR_button`=byte2 and `ir_address`=byte0, pulse `button_valid`, set `have_cmd`.
  - Fail: pulse `frame_error`, outputs unchanged.
- REP_STOP completion: if `have_cmd`, pulse `button_repeat` with outputs unchanged. Otherwise it is ignored silently.
- Only one of the three pulses can be asserted in any cycle.

## Timing
- Reset values:
  - `IR_button`=8'h00, `ir_address`=8'h00, all pulses 0.
  - state=IDLE, counter=0, shift register=0, `have_cmd`=0, synchronizer=1.
- Reset mid-frame discards the partial frame, with no error pulse.
- Pin-to-sync latency is 2 cycles.
- A pulse asserts on the cycle after the synchronized rising edge that ends the stop burst (3 cycles after the pin edge). It lasts exactly 1 cycle.
- `IR_button` and `ir_address` update on the same cycle that `button_valid` asserts.
- A falling edge arriving in the same cycle as a timeout counts as the edge, not the timeout.
- The counter never wraps; saturation only matters in IDLE.

## Structure
- Package `ir_nec_pkg` holds:
  - the state enum (IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH, STOP, REP_STOP);
  - the µs window constants;
  - a `us_to_cycles` function.
- Sub-module `ir_edge_timer` contains the synchronizer, edge detector and saturating duration counter. It outputs `rise`, `fall`, `level` and `duration`.
- The top module contains the FSM, the 32-bit shift register, the checker and the output registers.

## Test plan
Run the bench at CLK_KHZ=1000 (1 cycle = 1 µs).

- Frame with address 8'h00 and command 8'h18 (bytes 00 FF 18 E7), nominal timing: 9000 low, 4500 high, bursts of 560, spaces of 560 or 1690, then stop. Required: one `button_valid`, `IR_button`=8'h18, `ir_address`=8'h00, 3 cycles after the stop-burst rising edge.
- Repeat code (9000 low, 2250 high, 560 stop):
  - After the first test: one `button_repeat`, `IR_button` still 8'h18.
  - Straight after reset: no pulse.
- Command byte 8'h18 with inverse byte 8'hE6: one `frame_error`, no `button_valid`, `IR_button` unchanged.
- Line held low for 300 cycles: no pulse, state IDLE. Line held low after a valid leader at bit 10 until 701 cycles: `frame_error` on cycle 701.
- Assert `reset` at bit 20: outputs 0, no pulse. The next nominal frame with command 8'h45 decodes correctly.
- Jitter at the window edges:
  - Spaces of 1400 and 1900, leader 8000: valid.
  - Space of 1399: `frame_error`.

Source files
------------

// File: rtl/ir_nec_pkg.sv
// NEC IR decoder shared types, pulse windows (microseconds) and cycle conversion.
// Pure definitions: no latency, no backpressure.
package ir_nec_pkg;

  localparam int DUR_W = 20;

  typedef logic [DUR_W-1:0] dur_t;
  typedef logic [DUR_W:0]   len_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    LEAD_HIGH,
    BIT_LOW,
    BIT_HIGH,
    STOP,
    REP_STOP
  } state_t;

  localparam int unsigned LEAD_LOW_MIN_US = 8000;
  localparam int unsigned LEAD_LOW_MAX_US = 10000;
  localparam int unsigned LEAD_NEW_MIN_US = 4000;
  localparam int unsigned LEAD_NEW_MAX_US = 5000;
  localparam int unsigned LEAD_REP_MIN_US = 2000;
  localparam int unsigned LEAD_REP_MAX_US = 2500;
  localparam int unsigned BURST_MIN_US    = 400;
  localparam int unsigned BURST_MAX_US    = 700;
  localparam int unsigned SPACE0_MIN_US   = 400;
  localparam int unsigned SPACE0_MAX_US   = 700;
  localparam int unsigned SPACE1_MIN_US   = 1400;
  localparam int unsigned SPACE1_MAX_US   = 1900;

  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned clk_khz);
    return (us * clk_khz) / 1000;
  endfunction

endpackage

// File: rtl/ir_edge_timer.sv
// Synchronizes the IR pin, flags edges and counts cycles since the last edge (saturating).
// Sync latency 2 cycles, edge flags combinational off the synced level; no backpressure.
module ir_edge_timer
  import ir_nec_pkg::*;
(
  input  logic clk_50,
  input  logic reset,
  input  logic irda_rxd,
  output logic rise,
  output logic fall,
  output logic level,
  output dur_t duration
);

  logic sync1_q, sync2_q, prev_q;
  dur_t cnt_q, cnt_d;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= irda_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign rise  = sync2_q & ~prev_q;
  assign fall  = ~sync2_q & prev_q;
  assign level = sync2_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + dur_t'(1);
    end
  end

  assign duration = cnt_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC frame decoder: classifies pulse widths, shifts 32 bits LSB first, checks inverted bytes.
// Result pulses register one cycle after the synced edge ending the stop burst; no backpressure.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int unsigned CLK_KHZ    = 50_000,
  parameter bit          CHECK_ADDR = 1'b1
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       irda_rxd,
  output logic [7:0] IR_button,
  output logic [7:0] ir_address,
  output logic       button_valid,
  output logic       button_repeat,
  output logic       frame_error
);

  localparam len_t LL_MIN = len_t'(us_to_cycles(LEAD_LOW_MIN_US, CLK_KHZ));
  localparam len_t LL_MAX = len_t'(us_to_cycles(LEAD_LOW_MAX_US, CLK_KHZ));
  localparam len_t LN_MIN = len_t'(us_to_cycles(LEAD_NEW_MIN_US, CLK_KHZ));
  localparam len_t LN_MAX = len_t'(us_to_cycles(LEAD_NEW_MAX_US, CLK_KHZ));
  localparam len_t LR_MIN = len_t'(us_to_cycles(LEAD_REP_MIN_US, CLK_KHZ));
  localparam len_t LR_MAX = len_t'(us_to_cycles(LEAD_REP_MAX_US, CLK_KHZ));
  localparam len_t B_MIN  = len_t'(us_to_cycles(BURST_MIN_US, CLK_KHZ));
  localparam len_t B_MAX  = len_t'(us_to_cycles(BURST_MAX_US, CLK_KHZ));
  localparam len_t S0_MIN = len_t'(us_to_cycles(SPACE0_MIN_US, CLK_KHZ));
  localparam len_t S0_MAX = len_t'(us_to_cycles(SPACE0_MAX_US, CLK_KHZ));
  localparam len_t S1_MIN = len_t'(us_to_cycles(SPACE1_MIN_US, CLK_KHZ));
  localparam len_t S1_MAX = len_t'(us_to_cycles(SPACE1_MAX_US, CLK_KHZ));

  state_t      state_q, state_d;
  logic        rise, fall, level;
  dur_t        duration;
  len_t        len, phase_max;
  logic        want_rise, phase_end, phase_ok, timeout, abort, frame_ok;
  logic        win_ll, win_new, win_rep, win_burst, win_s0, win_s1;
  logic [31:0] shift_q;
  logic [4:0]  idx_q;
  logic        have_cmd_q;
  logic [7:0]  cmd_q, addr_q;
  logic        valid_q, valid_d, repeat_q, repeat_d, error_q, error_d, shift_en;

  ir_edge_timer u_timer (
    .clk_50   (clk_50),
    .reset    (reset),
    .irda_rxd (irda_rxd),
    .rise     (rise),
    .fall     (fall),
    .level    (level),
    .duration (duration)
  );

  function automatic logic in_win(input len_t v, input len_t lo, input len_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Counter clears on the edge, so the phase length including the current cycle is one more.
  assign len       = len_t'(duration) + len_t'(1);
  assign win_ll    = in_win(len, LL_MIN, LL_MAX);
  assign win_new   = in_win(len, LN_MIN, LN_MAX);
  assign win_rep   = in_win(len, LR_MIN, LR_MAX);
  assign win_burst = in_win(len, B_MIN, B_MAX);
  assign win_s0    = in_win(len, S0_MIN, S0_MAX);
  assign win_s1    = in_win(len, S1_MIN, S1_MAX);

  always_comb begin
    phase_max = '1;
    phase_ok  = 1'b0;
    want_rise = 1'b1;
    case (state_q)
      LEAD_LOW: begin
        phase_max = LL_MAX;
        phase_ok  = win_ll;
      end
      LEAD_HIGH: begin
        phase_max = LN_MAX;
        phase_ok  = win_new | win_rep;
        want_rise = 1'b0;
      end
      BIT_LOW, STOP, REP_STOP: begin
        phase_max = B_MAX;
        phase_ok  = win_burst;
      end
      BIT_HIGH: begin
        phase_max = S1_MAX;
        phase_ok  = win_s0 | win_s1;
        want_rise = 1'b0;
      end
      default: ;
    endcase
  end

  assign phase_end = (rise | fall) && (level == want_rise) && (state_q != IDLE);
  assign timeout   = !phase_end && (len > phase_max);
  assign abort     = timeout || (phase_end && !phase_ok);
  assign frame_ok  = (shift_q[23:16] == ~shift_q[31:24]) &&
                     (!CHECK_ADDR || (shift_q[7:0] == ~shift_q[15:8]));

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (fall) state_d = LEAD_LOW;
    end else if (abort) begin
      state_d = IDLE;
    end else if (phase_end) begin
      case (state_q)
        LEAD_LOW:  state_d = LEAD_HIGH;
        LEAD_HIGH: state_d = win_new ? BIT_LOW : REP_STOP;
        BIT_LOW:   state_d = BIT_HIGH;
        BIT_HIGH:  state_d = (idx_q == 5'd31) ? STOP : BIT_LOW;
        default:   state_d = IDLE;
      endcase
    end
  end

  // A leader low that ends early is treated as line noise and dropped silently.
  always_comb begin
    valid_d  = 1'b0;
    repeat_d = 1'b0;
    error_d  = 1'b0;
    shift_en = 1'b0;
    if (abort) begin
      error_d = !(state_q == LEAD_LOW && phase_end && len < LL_MIN);
    end else if (phase_end) begin
      case (state_q)
        BIT_HIGH: shift_en = 1'b1;
        STOP: begin
          valid_d = frame_ok;
          error_d = !frame_ok;
        end
        REP_STOP: repeat_d = have_cmd_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      shift_q    <= '0;
      idx_q      <= '0;
      have_cmd_q <= 1'b0;
      cmd_q      <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      repeat_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      repeat_q <= repeat_d;
      error_q  <= error_d;
      if (state_q == LEAD_HIGH) idx_q <= '0;
      if (shift_en) begin
        shift_q <= {win_s1, shift_q[31:1]};
        idx_q   <= idx_q + 5'd1;
      end
      if (valid_d) begin
        cmd_q      <= shift_q[23:16];
        addr_q     <= shift_q[7:0];
        have_cmd_q <= 1'b1;
      end
    end
  end

  assign IR_button     = cmd_q;
  assign ir_address    = addr_q;
  assign button_valid  = valid_q;
  assign button_repeat = repeat_q;
  assign frame_error   = error_q;

endmodule
